// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined segmented ripple-carry adder/subtractor with valid/ready
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Mask selecting segment 0; shifted to address segment k.
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

  generate
    if ((SEG < 1) || (WIDTH % SEG != 0)) begin : g_param_check
      $error("pipe_addsub: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  // Per-stage registered state. r_sum holds completed (deskewed) low segments,
  // r_a/r_b carry the still-unprocessed (skewed) upper operand segments.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic              r_ovf;

  // Stage inputs (from ports for stage 0, from the previous stage otherwise).
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_in;
  logic [WIDTH-1:0]  w_s_in [STAGES];
  logic [WIDTH-1:0]  w_a_in [STAGES];
  logic [WIDTH-1:0]  w_b_in [STAGES];

  // Stage results.
  logic [SEG:0]      w_seg   [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [STAGES-1:0] w_c_out;
  logic              w_ovf_nxt;

  logic              w_advance;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;

  // Whole pipe moves together; a bubble in the output slot never blocks.
  assign w_advance = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_advance;

  // Subtraction is A + ~B + 1; Cin only matters in add mode.
  assign w_b_eff = sub ? ~B : B;
  assign w_c0    = sub ? 1'b1 : Cin;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_v_in[k] = in_valid;
        assign w_c_in[k] = w_c0;
        assign w_s_in[k] = '0;
        assign w_a_in[k] = A;
        assign w_b_in[k] = w_b_eff;
      end else begin : g_rest
        assign w_v_in[k] = r_valid[k-1];
        assign w_c_in[k] = r_carry[k-1];
        assign w_s_in[k] = r_sum[k-1];
        assign w_a_in[k] = r_a[k-1];
        assign w_b_in[k] = r_b[k-1];
      end

      assign w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                      + {1'b0, w_b_in[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, w_c_in[k]};

      assign w_c_out[k] = w_seg[k][SEG];

      // Splice this stage's partial sum into segment k, keep lower segments.
      assign w_s_nxt[k] = (w_s_in[k] & ~(SEG_MASK << (k*SEG)))
                        | (WIDTH'(w_seg[k][SEG-1:0]) << (k*SEG));
    end
  endgenerate

  // Overflow uses the operand MSBs that travelled skewed to the last stage.
  assign w_ovf_nxt = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1])
                  && (w_s_nxt[STAGES-1][WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);

  // Pipeline registers: clear everything on reset, shift all stages on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_v_in;
      r_carry <= w_c_out;
      r_ovf   <= w_ovf_nxt;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= w_s_nxt[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign Sum       = r_sum[STAGES-1];
  assign Cout      = r_carry[STAGES-1];
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - directed self-checking bench for pipe_addsub
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_s [8];
  logic        exp_o [8];
  logic [15:0] held_sum;

  pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    sub      = s;
  endtask

  // One beat through an otherwise empty pipe: 4-cycle latency, then pop.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    drive(1'b1, a, b, c, s);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk({tag, "_early1"}, {31'b0, out_valid}, 32'd0);
    step();
    chk({tag, "_early2"}, {31'b0, out_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'b0, Sum},       {16'b0, es});
    chk({tag, "_cout"},  {31'b0, Cout},      {31'b0, ec});
    chk({tag, "_ovf"},   {31'b0, Ovf},       {31'b0, eo});
    step();
    chk({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    exp_s = '{16'h1001, 16'hE002, 16'h3003, 16'hC004, 16'h5005, 16'hA006, 16'h7007, 16'h8008};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum",       {16'b0, Sum},       32'd0);
    chk("rst_cout",      {31'b0, Cout},      32'd0);
    chk("rst_ovf",       {31'b0, Ovf},       32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    // Single operations and carry/overflow corners.
    single("add_6_4",     16'h0006, 16'h0004, 1'b0, 1'b0, 16'h000A, 1'b0, 1'b0);
    single("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("add_7fff_c",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("sub_cin_ign", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Streaming: 8 back-to-back beats, alternating add/sub.
    for (int t = 1; t <= 12; t++) begin
      if (t <= 8)
        drive(1'b1, 16'(t), 16'(t * 16'h1000), 1'b0, (t % 2) == 0);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      step();
      if (t == 3 || t == 12) begin
        chk($sformatf("stream_idle_%0d", t), {31'b0, out_valid}, 32'd0);
      end else if (t >= 4 && t <= 11) begin
        chk($sformatf("stream_valid_%0d", t - 3), {31'b0, out_valid}, 32'd1);
        chk($sformatf("stream_sum_%0d", t - 3),   {16'b0, Sum},       {16'b0, exp_s[t-4]});
        chk($sformatf("stream_cout_%0d", t - 3),  {31'b0, Cout},      32'd0);
        chk($sformatf("stream_ovf_%0d", t - 3),   {31'b0, Ovf},       {31'b0, exp_o[t-4]});
      end
    end

    // Backpressure: fill the pipe with 4 beats, stall 3 cycles, drain.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k * 16'h0100), 16'(k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    held_sum = 16'h0101;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_hold_valid_%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_hold_sum_%0d", k),   {16'b0, Sum},       {16'b0, held_sum});
      chk($sformatf("bp_hold_rdy_%0d", k),   {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'b0, in_ready}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("bp_drain_valid_%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_drain_sum_%0d", k),   {16'b0, Sum},       {16'b0, 16'(k * 16'h0101)});
    end
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-flight: 3 beats in flight are discarded.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 16'(k), 16'h0010, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_sum",   {16'b0, Sum},       32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("mid_rst_quiet_%0d", k), {31'b0, out_valid}, 32'd0);
    end
    single("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Generalises the 4-bit full-adder block to WIDTH bits.
- The carry chain is cut into SEG-bit segments, with one register stage per segment. Adds valid/ready flow control, add/sub mode and signed-overflow flag.
- Sits in the datapath as a throughput-1 arithmetic unit.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SEG, 4, bits per pipeline segment. WIDTH % SEG == 0 is required; elaboration fails otherwise.
- STAGES, WIDTH/SEG, derived; pipeline depth = latency in accepted cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry-in (add mode only)
- sub  in  1  0 = A+B+Cin, 1 = A-B
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts
- Sum  out  WIDTH  result
- Cout  out  1  carry-out (sub: 1 = no borrow)
- Ovf  out  1  two's-complement overflow

Behaviour:
- Reset: async assert clears all stage valids. out_valid=0, Sum=0, Cout=0, Ovf=0. in_ready=1 after reset. Internal data registers are cleared too.
- Effective operands:
  - Add: B' = B, c0 = Cin.
  - Sub: B' = ~B, c0 = 1. Cin is ignored in sub mode.
- Stage k (0..STAGES-1) adds segment k of A and B' with carry from stage k-1 (stage 0 uses c0). It registers the SEG-bit partial sum and the carry.
- Upper unprocessed segments are skewed forward; completed lower segments are deskewed. Sum reaches the output fully aligned.
- Global advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance=1, every stage shifts one position.
  - When advance=0, all stages hold, including bubbles.
- Accept occurs when in_valid && in_ready. The result appears with out_valid=1 exactly STAGES advancing cycles later; latency is STAGES cycles with no stalls.
- Throughput: one op per cycle when out_ready is held high. Bubbles (in_valid=0) propagate as invalid slots and do not stall.
- Output hold: while out_valid=1 && out_ready=0, Sum/Cout/Ovf/out_valid hold stable.
- Output handshake: out_valid must not depend combinationally on out_ready.
- Cout = carry out of the MSB segment.
- Ovf = (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]). It is computed in the final stage from the skewed MSBs.
- Wrap-around: Sum is modulo 2^WIDTH; no saturation.
- Simultaneous output pop and input accept in the same cycle is legal; no beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded. No out_valid is asserted for them after rst_n deasserts.
- Mode (sub/Cin) is captured per beat at accept; mixed add/sub streams are legal.

Test Plan:
All scenarios use WIDTH=16, SEG=4, STAGES=4.
1. Single add: A=0x0006, B=0x0004, Cin=0, sub=0 -> 4 cycles later out_valid=1, Sum=0x000A, Cout=0, Ovf=0.
2. Full-chain carry: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0.
   Also A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1.
3. Subtract: A=0x0005, B=0x0007, sub=1 -> Sum=0xFFFE, Cout=0, Ovf=0.
   Also A=0x8000, B=0x0001, sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
4. Streaming: 8 back-to-back beats A=i, B=0x1000*i (i=1..8), with sub alternating, out_ready=1 -> 8 consecutive out_valid cycles starting cycle 4, results match the model in order.
5. Backpressure: fill the pipe, hold out_ready=0 for 3 cycles -> in_ready=0, outputs frozen. Release -> all 4 beats delivered in order, none lost or duplicated.
6. Reset mid-flight: 3 beats accepted, rst_n pulsed low 1 cycle -> out_valid=0 immediately and stays 0 until new beats are accepted. Next accepted beat emerges after exactly 4 cycles.
